// File: rtl/rf_seq_pkg.sv
// ---------------------------------------------------------------------------
// rf_seq_pkg
// Shared definitions for the register-file ALU sequencer:
//   DATA_W / ADDR_W : register width and register address width (64 x 16 RF)
//   opcode_t        : 3-bit instruction opcode
//   state_t         : sequencer FSM states
//   alu_out_t       : ALU result plus carry/borrow
// ---------------------------------------------------------------------------
package rf_seq_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 6;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_MOV = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              carry;
    } alu_out_t;

endpackage

// File: rtl/rf_seq_alu.sv
// ---------------------------------------------------------------------------
// rf_seq_alu
// Purely combinational ALU for the sequencer's EXEC stage.
// Ports:
//   op_i     : opcode (rf_seq_pkg::opcode_t encoding)
//   a_i, b_i : operands captured from the register file
//   imm_i    : immediate used by LDI
//   result_o : 16-bit result, modulo 2^DATA_W (NOP yields 0)
//   carry_o  : carry-out of ADD, borrow (a < b unsigned) of SUB, else 0
// ---------------------------------------------------------------------------
module rf_seq_alu
    import rf_seq_pkg::*;
(
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    alu_out_t          res;
    logic [DATA_W:0]   wide;

    always_comb begin
        res  = '0;
        wide = '0;
        case (opcode_t'(op_i))
            OP_ADD: begin
                wide       = {1'b0, a_i} + {1'b0, b_i};
                res.result = wide[DATA_W-1:0];
                res.carry  = wide[DATA_W];
            end
            OP_SUB: begin
                // Top bit of the extended difference is the borrow (a < b).
                wide       = {1'b0, a_i} - {1'b0, b_i};
                res.result = wide[DATA_W-1:0];
                res.carry  = wide[DATA_W];
            end
            OP_AND:  res.result = a_i & b_i;
            OP_OR:   res.result = a_i | b_i;
            OP_XOR:  res.result = a_i ^ b_i;
            OP_LDI:  res.result = imm_i;
            OP_MOV:  res.result = a_i;
            default: res        = '0;
        endcase
    end

    assign result_o = res.result;
    assign carry_o  = res.carry;

endmodule

// File: rtl/rf_alu_sequencer.sv
// ---------------------------------------------------------------------------
// rf_alu_sequencer
// Initiator-side controller for a 64x16 register file. Accepts one
// instruction over a valid/ready handshake, reads two source registers,
// computes an ALU result and writes it back through RF port A. One
// instruction every 4 cycles: IDLE -> READ -> EXEC -> WRITE -> IDLE.
//
// Optional feature: define RF_SEQ_FLAGS_EN to add registered ZeroFlag and
// CarryFlag outputs, updated at the edge that ends the WRITE cycle.
//
// Ports:
//   Clock, Reset           : clock (rising edge), async active-high reset
//   InstrValid/InstrReady  : instruction handshake
//   InstrOp/Dst/SrcA/SrcB/Imm : instruction fields
//   RfAddressA/B           : RF addresses (A is also the write address)
//   RfWriteData/WriteEnable: RF write port
//   RfReadDataA/B          : RF combinational read data
//   DoneValid/DoneResult   : completion pulse and result (result holds)
//   ZeroFlag/CarryFlag     : status flags (RF_SEQ_FLAGS_EN only)
// ---------------------------------------------------------------------------
module rf_alu_sequencer
    import rf_seq_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InstrValid,
    output logic              InstrReady,
    input  logic [2:0]        InstrOp,
    input  logic [ADDR_W-1:0] InstrDst,
    input  logic [ADDR_W-1:0] InstrSrcA,
    input  logic [ADDR_W-1:0] InstrSrcB,
    input  logic [DATA_W-1:0] InstrImm,
    output logic [ADDR_W-1:0] RfAddressA,
    output logic [ADDR_W-1:0] RfAddressB,
    output logic [DATA_W-1:0] RfWriteData,
    output logic              RfWriteEnable,
    input  logic [DATA_W-1:0] RfReadDataA,
    input  logic [DATA_W-1:0] RfReadDataB,
    output logic              DoneValid,
`ifdef RF_SEQ_FLAGS_EN
    output logic              ZeroFlag,
    output logic              CarryFlag,
`endif
    output logic [DATA_W-1:0] DoneResult
);

    state_t            state_q, state_d;
    opcode_t           op_q;
    logic [ADDR_W-1:0] dst_q, srca_q, srcb_q;
    logic [DATA_W-1:0] imm_q, opa_q, opb_q, result_q;

    logic              ready;
    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    // Ready is gated by Reset so it reads 0 for the whole reset pulse even
    // though the state register already sits in IDLE.
    assign ready  = (state_q == S_IDLE) && !Reset;
    assign accept = InstrValid && ready;

    rf_seq_alu u_alu (
        .op_i     (op_q),
        .a_i      (opa_q),
        .b_i      (opb_q),
        .imm_i    (imm_q),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        InstrReady    = 1'b0;
        RfAddressA    = '0;
        RfAddressB    = '0;
        RfWriteData   = '0;
        RfWriteEnable = 1'b0;
        DoneValid     = 1'b0;
        case (state_q)
            S_IDLE: begin
                InstrReady = ready;
                if (accept) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                RfAddressA = srca_q;
                RfAddressB = srcb_q;
                state_d    = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                RfAddressA    = dst_q;
                RfWriteData   = result_q;
                RfWriteEnable = (op_q != OP_NOP);
                DoneValid     = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            op_q     <= OP_NOP;
            dst_q    <= '0;
            srca_q   <= '0;
            srcb_q   <= '0;
            imm_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= opcode_t'(InstrOp);
                dst_q  <= InstrDst;
                srca_q <= InstrSrcA;
                srcb_q <= InstrSrcB;
                imm_q  <= InstrImm;
            end
            // Operands are sampled before any write-back, so Dst==Src uses
            // the old register value.
            if (state_q == S_READ) begin
                opa_q <= RfReadDataA;
                opb_q <= RfReadDataB;
            end
            if (state_q == S_EXEC) begin
                result_q <= alu_result;
            end
        end
    end

    // result_q only changes at the EXEC edge, so it doubles as the
    // held DoneResult between completions.
    assign DoneResult = result_q;

`ifdef RF_SEQ_FLAGS_EN
    logic carry_q;
    logic zero_flag_q, carry_flag_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            carry_q      <= 1'b0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            if (state_q == S_EXEC) begin
                carry_q <= alu_carry;
            end
            // ALU drives carry 0 for logic/LDI/MOV, which clears the flag.
            if (state_q == S_WRITE && op_q != OP_NOP) begin
                zero_flag_q  <= (result_q == '0);
                carry_flag_q <= carry_q;
            end
        end
    end

    assign ZeroFlag  = zero_flag_q;
    assign CarryFlag = carry_flag_q;
`else
    logic carry_unused;
    assign carry_unused = alu_carry;
`endif

endmodule
